inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch front end of the pipeline. Owns the program counter, issues word reads to instruction memory over a req/ack handshake and presents `pc`, `inst` and fetch-exception information to the IF/ID pipeline register. It applies branch/jump redirects with MIPS delay-slot semantics, honours decode/execute stalls and interrupt/exception flushes, and raises AdEL for misaligned fetch addresses.

## Interface
- `RESET_PC`, 32'hBFC0_0000, first fetch address after reset
- `clk`  in  1  clock, all state on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `jmp`  in  1  decode resolved a taken branch/jump for the instruction in IF/ID
- `jmp_target`  in  32  redirect address, valid with `jmp`
- `hazard_stall`  in  1  decode stall; IF/ID holds
- `exe_stall`  in  1  execute stall; IF/ID holds
- `int_flush`  in  1  exception/ERET flush; IF/ID clears
- `int_target`  in  32  handler or EPC address, valid with `int_flush`
- `imem_req`  out  1  read request
- `imem_addr`  out  32  word address, stable while `imem_req` high and no `imem_ack`
- `imem_ack`  in  1  read complete this cycle
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`
- `pc`  out  32  address of presented instruction
- `inst`  out  32  presented instruction; 0 (NOP) when bubble
- `cp0_ex`  out  1  presented slot carries a fetch exception
- `cp0_excode`  out  5  exception code (AdEL = 5'h04)
- `cp0_badvaddr`  out  32  faulting fetch address

## Operation
- `stall = hazard_stall | exe_stall`; a slot is *accepted* in a cycle where it is presented valid and `stall`=0 and `int_flush`=0.
- States: FETCH (request outstanding), HOLD (word buffered, waiting for accept), DROP (request outstanding whose data must be discarded).
- FETCH: `imem_req`=1, `imem_addr`=`pc_r`. On `imem_ack`: word passes combinationally to `inst`, `pc`=`pc_r`. If accepted, `pc_r` advances and FETCH continues; else word latched into buffer, go HOLD.
- HOLD: `imem_req`=0; present buffer; on accept advance `pc_r`, go FETCH.
- No valid slot: `pc`=0, `inst`=0, `cp0_ex`=0, `cp0_excode`=0, `cp0_badvaddr`=0.
- Next PC on accept: pending jump target if one is latched, else `jmp_target` if `jmp`=1 that cycle, else `pc_r`+4 (32-bit wrap).
- `jmp` is sampled only when `stall`=0. If sampled while no slot is accepted, target is latched as pending and consumed by the next accepted slot (the delay slot is always delivered).
- Misaligned `pc_r` (`pc_r[1:0]`≠0): no request issued; slot is immediately valid with `inst`=0, `cp0_ex`=1, `cp0_excode`=5'h04, `cp0_badvaddr`=`pc_r`, `pc`=`pc_r`; accepted like any slot.
- `int_flush` (highest priority): pending jump cleared, buffer dropped, `pc_r`←`int_target`. If a request is outstanding without ack this cycle, go DROP; else FETCH.
- DROP: hold `imem_req`/old address until `imem_ack`, discard data, then FETCH at `pc_r`. A further `int_flush` in DROP just updates `pc_r`.
- Simultaneous `int_flush` and `jmp`: flush wins, jump ignored. Simultaneous `imem_ack` and `int_flush` in FETCH: data discarded, FETCH at `int_target` next cycle.

## Timing
- Reset (async, any state, including mid-request): `pc_r`=`RESET_PC`, state FETCH, buffer/pending cleared; all outputs 0 while `resetn`=0 (`imem_req`=0).
- First `imem_req` in the first cycle after `resetn` deasserts.
- Zero-wait memory (ack in request cycle): one instruction per cycle; `imem_rdata`→`inst` is combinational, zero latency.
- N wait cycles: N bubbles presented before the slot.
- Redirect latency: target requested the cycle after the delay slot is accepted.

## Structure
- Shared package: `RESET_PC` default, `EXC_ADEL`=5'h04, fetch state enum.
- One sub-module natural: `inst_skid_buf`, one-entry holding register (pc, inst, ex fields) with load/clear/valid.

## Test plan
- Reset release, ack every cycle with 0x24020001, 0x24030002 -> `imem_addr` BFC00000, BFC00004; `inst` matches each cycle, no bubbles.
- Ack at BFC00000 with `hazard_stall`=1 for 3 cycles -> `imem_req`=0 during HOLD, `inst` held; after release next request BFC00004.
- `jmp`=1, `jmp_target`=80001000 while BFC00004 has 2 wait cycles -> BFC00004 delivered, next request 80001000.
- `jmp_target`=80000002 -> slot `cp0_ex`=1, `cp0_excode`=04, `cp0_badvaddr`=80000002, no `imem_req` for it.
- `int_flush`, `int_target`=BFC00380 mid-wait -> old request held to ack, data not presented, next request BFC00380.
- `resetn` pulsed low mid-request -> `imem_req`=0 immediately; restart at BFC00000.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_pkg
// Purpose  : Shared constants, fetch FSM encoding and slot record for inst_fetch.
// Revision : 1.0
// ============================================================================
package inst_fetch_pkg;

    localparam logic [31:0] C_RESET_PC = 32'hBFC0_0000;
    localparam logic [4:0]  C_EXC_ADEL = 5'h04;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
    } slot_t;

endpackage : inst_fetch_pkg
`default_nettype wire

// File: rtl/inst_fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : inst_skid_buf
// Purpose  : One-entry holding register for a fetched slot awaiting accept.
// Revision : 1.0
// ============================================================================
module inst_skid_buf
    import inst_fetch_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    input  logic  load,
    input  logic  clear,
    input  slot_t d,
    output logic  valid,
    output slot_t q
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule : inst_skid_buf
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : PC owner and instruction-memory fetch front end with delay-slot
//            redirects, stall hold, flush and AdEL detection.
// Revision : 1.0
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        hazard_stall,
    input  logic        exe_stall,
    input  logic        int_flush,
    input  logic [31:0] int_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        cp0_ex,
    output logic [4:0]  cp0_excode,
    output logic [31:0] cp0_badvaddr
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_drop_addr;
    logic [31:0]  r_pend_target;
    logic         r_pend_valid;

    slot_t        w_slot;
    slot_t        w_buf_q;
    logic         w_buf_valid;
    logic         w_buf_load;
    logic         w_buf_clear;
    logic         w_slot_valid;
    logic         w_stall;
    logic         w_accept;
    logic         w_jmp_take;
    logic         w_outstanding;
    logic [31:0]  w_pc_next;

    inst_skid_buf u_skid_buf (
        .clk    (clk),
        .resetn (resetn),
        .load   (w_buf_load),
        .clear  (w_buf_clear),
        .d      (w_slot),
        .valid  (w_buf_valid),
        .q      (w_buf_q)
    );

    always_comb begin
        w_state_nxt   = r_state;
        imem_req      = 1'b0;
        imem_addr     = 32'h0;
        w_slot_valid  = 1'b0;
        w_slot        = '0;
        w_buf_load    = 1'b0;
        w_buf_clear   = 1'b0;
        w_outstanding = 1'b0;
        w_stall       = hazard_stall | exe_stall;

        case (r_state)
            ST_FETCH: begin
                if (r_pc[1:0] != 2'b00) begin
                    // Misaligned PC: never touch memory, present AdEL slot at once.
                    w_slot_valid    = 1'b1;
                    w_slot.pc       = r_pc;
                    w_slot.ex       = 1'b1;
                    w_slot.excode   = C_EXC_ADEL;
                    w_slot.badvaddr = r_pc;
                end else begin
                    imem_req      = 1'b1;
                    imem_addr     = r_pc;
                    w_outstanding = ~imem_ack;
                    if (imem_ack) begin
                        w_slot_valid = 1'b1;
                        w_slot.pc    = r_pc;
                        w_slot.inst  = imem_rdata;
                    end
                end
            end
            ST_HOLD: begin
                w_slot_valid = w_buf_valid;
                w_slot       = w_buf_q;
            end
            ST_DROP: begin
                imem_req      = 1'b1;
                imem_addr     = r_drop_addr;
                w_outstanding = ~imem_ack;
            end
            default: ;
        endcase

        // Outputs stay quiet for the whole time reset is asserted.
        if (!resetn) begin
            imem_req      = 1'b0;
            imem_addr     = 32'h0;
            w_slot_valid  = 1'b0;
            w_outstanding = 1'b0;
        end
        if (!w_slot_valid) begin
            w_slot = '0;
        end

        w_accept   = w_slot_valid & ~w_stall & ~int_flush;
        w_jmp_take = jmp & ~w_stall & ~int_flush;

        if (r_pend_valid) begin
            w_pc_next = r_pend_target;
        end else if (w_jmp_take) begin
            w_pc_next = jmp_target;
        end else begin
            w_pc_next = r_pc + 32'd4;
        end

        if (int_flush) begin
            w_buf_clear = 1'b1;
            w_state_nxt = w_outstanding ? ST_DROP : ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_slot_valid && !w_accept) begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_accept) begin
                        w_buf_clear = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        w_state_nxt = ST_FETCH;
                    end
                end
                default: w_state_nxt = ST_FETCH;
            endcase
        end

        pc           = w_slot.pc;
        inst         = w_slot.inst;
        cp0_ex       = w_slot.ex;
        cp0_excode   = w_slot.excode;
        cp0_badvaddr = w_slot.badvaddr;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc          <= RESET_PC;
            r_drop_addr   <= 32'h0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'h0;
        end else if (int_flush) begin
            r_pc         <= int_target;
            r_pend_valid <= 1'b0;
            if (r_state == ST_FETCH) begin
                r_drop_addr <= r_pc;
            end
        end else if (w_accept) begin
            r_pc         <= w_pc_next;
            r_pend_valid <= 1'b0;
        end else if (w_jmp_take) begin
            // Branch resolved before its delay slot arrived; redirect later.
            r_pend_valid  <= 1'b1;
            r_pend_target <= jmp_target;
        end
    end

endmodule : inst_fetch
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Self-checking bench for inst_fetch with a wait-state memory model.
// Revision : 1.0
// ============================================================================
module tb_inst_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
    } exp_slot_t;

    logic        clk;
    logic        resetn;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        hazard_stall;
    logic        exe_stall;
    logic        int_flush;
    logic [31:0] int_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        cp0_ex;
    logic [4:0]  cp0_excode;
    logic [31:0] cp0_badvaddr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_req_q [$];
    exp_slot_t   exp_slot_q [$];
    bit          mon_en = 1'b0;
    logic [31:0] mon_addr;
    exp_slot_t   mon_slot;

    logic [31:0] slow_addr = 32'hFFFF_FFFF;
    int          slow_wait = 0;
    int          wcnt      = 0;

    inst_fetch dut (
        .clk          (clk),
        .resetn       (resetn),
        .jmp          (jmp),
        .jmp_target   (jmp_target),
        .hazard_stall (hazard_stall),
        .exe_stall    (exe_stall),
        .int_flush    (int_flush),
        .int_target   (int_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .inst         (inst),
        .cp0_ex       (cp0_ex),
        .cp0_excode   (cp0_excode),
        .cp0_badvaddr (cp0_badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'hBFC0_0000: return 32'h2402_0001;
            32'hBFC0_0004: return 32'h2403_0002;
            default:       return a ^ 32'h3C1D_5A5A;
        endcase
    endfunction

    // Memory responder: acks after slow_wait cycles for slow_addr, else same cycle.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (imem_req) begin
                if (wcnt >= ((imem_addr == slow_addr) ? slow_wait : 0)) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    wcnt       = 0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = 32'hDEAD_BEEF;
                    wcnt++;
                end
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'h0;
                wcnt       = 0;
            end
        end
    end

    // Scoreboard: acked request addresses and accepted slots, in order.
    always @(negedge clk) begin
        if (mon_en && resetn) begin
            if (imem_req && imem_ack && exp_req_q.size() > 0) begin
                mon_addr = exp_req_q.pop_front();
                checks++;
                if (imem_addr !== mon_addr) begin
                    failures++;
                    $display("FAIL req_addr: got %h expected %h", imem_addr, mon_addr);
                end
            end
            if (pc != 32'h0 && !hazard_stall && !exe_stall && !int_flush && exp_slot_q.size() > 0) begin
                mon_slot = exp_slot_q.pop_front();
                checks++;
                if (pc !== mon_slot.pc || inst !== mon_slot.inst || cp0_ex !== mon_slot.ex ||
                    cp0_excode !== mon_slot.excode || cp0_badvaddr !== mon_slot.badvaddr) begin
                    failures++;
                    $display("FAIL slot: got pc=%h inst=%h ex=%b code=%h bad=%h expected pc=%h inst=%h ex=%b code=%h bad=%h",
                             pc, inst, cp0_ex, cp0_excode, cp0_badvaddr, mon_slot.pc, mon_slot.inst,
                             mon_slot.ex, mon_slot.excode, mon_slot.badvaddr);
                end
            end
        end
    end

    task automatic exp_ok(input logic [31:0] a);
        exp_slot_t s;
        s.pc = a; s.inst = mem_word(a); s.ex = 1'b0; s.excode = 5'h0; s.badvaddr = 32'h0;
        exp_slot_q.push_back(s);
    endtask

    task automatic exp_adel(input logic [31:0] a);
        exp_slot_t s;
        s.pc = a; s.inst = 32'h0; s.ex = 1'b1; s.excode = 5'h04; s.badvaddr = a;
        exp_slot_q.push_back(s);
    endtask

    // Ends at posedge+1 with resetn still low.
    task automatic hold_reset();
        mon_en = 1'b0;
        exp_req_q.delete();
        exp_slot_q.delete();
        jmp = 1'b0; jmp_target = 32'h0; hazard_stall = 1'b0; exe_stall = 1'b0;
        int_flush = 1'b0; int_target = 32'h0;
        slow_addr = 32'hFFFF_FFFF; slow_wait = 0;
        @(posedge clk); #1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_req_q.size() != 0 || exp_slot_q.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (exp_req_q.size() != 0 || exp_slot_q.size() != 0) begin
            failures++;
            $display("FAIL %s drain: req_left=%0d slot_left=%0d required 0", name,
                     exp_req_q.size(), exp_slot_q.size());
        end
        mon_en = 1'b0;
    endtask

    task automatic test_reset();
        hold_reset();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_req: got req=%b addr=%h expected 0 0", imem_req, imem_addr);
        end
        checks++;
        if (pc !== 32'h0 || inst !== 32'h0) begin
            failures++;
            $display("FAIL reset_slot: got pc=%h inst=%h expected 0 0", pc, inst);
        end
        checks++;
        if (cp0_ex !== 1'b0 || cp0_excode !== 5'h0 || cp0_badvaddr !== 32'h0) begin
            failures++;
            $display("FAIL reset_cp0: got ex=%b code=%h bad=%h expected 0", cp0_ex, cp0_excode, cp0_badvaddr);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000) begin
            failures++;
            $display("FAIL reset_first_req: got req=%b addr=%h expected 1 bfc00000", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        hold_reset();
        exp_req_q.push_back(32'hBFC0_0000);
        exp_req_q.push_back(32'hBFC0_0004);
        exp_req_q.push_back(32'hBFC0_0008);
        exp_ok(32'hBFC0_0000);
        exp_ok(32'hBFC0_0004);
        exp_ok(32'hBFC0_0008);
        mon_en = 1'b1;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pc !== (32'hBFC0_0000 + 32'(4 * i)) || inst !== mem_word(32'hBFC0_0000 + 32'(4 * i))) begin
                failures++;
                $display("FAIL stream_cycle%0d: got pc=%h inst=%h expected pc=%h", i, pc, inst,
                         32'hBFC0_0000 + 32'(4 * i));
            end
        end
        wait_drain("stream");
    endtask

    task automatic test_hold();
        hold_reset();
        exp_req_q.push_back(32'hBFC0_0000);
        exp_req_q.push_back(32'hBFC0_0004);
        exp_ok(32'hBFC0_0000);
        exp_ok(32'hBFC0_0004);
        mon_en = 1'b1;
        hazard_stall = 1'b1;
        resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || inst !== 32'h2402_0001 || pc !== 32'hBFC0_0000) begin
                failures++;
                $display("FAIL hold_stalled%0d: got req=%b pc=%h inst=%h expected 0 bfc00000 24020001",
                         i, imem_req, pc, inst);
            end
        end
        @(posedge clk); #1;
        hazard_stall = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || inst !== 32'h2402_0001) begin
            failures++;
            $display("FAIL hold_release: got req=%b inst=%h expected 0 24020001", imem_req, inst);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0004) begin
            failures++;
            $display("FAIL hold_next_req: got req=%b addr=%h expected 1 bfc00004", imem_req, imem_addr);
        end
        wait_drain("hold");
    endtask

    task automatic test_jump_wait();
        hold_reset();
        slow_addr = 32'hBFC0_0004;
        slow_wait = 2;
        exp_req_q.push_back(32'hBFC0_0000);
        exp_req_q.push_back(32'hBFC0_0004);
        exp_req_q.push_back(32'h8000_1000);
        exp_req_q.push_back(32'h8000_1004);
        exp_ok(32'hBFC0_0000);
        exp_ok(32'hBFC0_0004);
        exp_ok(32'h8000_1000);
        mon_en = 1'b1;
        resetn = 1'b1;
        @(posedge clk); #1;
        jmp = 1'b1;
        jmp_target = 32'h8000_1000;
        @(negedge clk);
        checks++;
        if (pc !== 32'h0 || inst !== 32'h0) begin
            failures++;
            $display("FAIL jump_bubble0: got pc=%h inst=%h expected 0 0", pc, inst);
        end
        @(posedge clk); #1;
        jmp = 1'b0;
        @(negedge clk);
        checks++;
        if (pc !== 32'h0 || inst !== 32'h0) begin
            failures++;
            $display("FAIL jump_bubble1: got pc=%h inst=%h expected 0 0", pc, inst);
        end
        @(negedge clk);
        checks++;
        if (pc !== 32'hBFC0_0004) begin
            failures++;
            $display("FAIL jump_delay_slot: got pc=%h expected bfc00004", pc);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8000_1000) begin
            failures++;
            $display("FAIL jump_target_req: got req=%b addr=%h expected 1 80001000", imem_req, imem_addr);
        end
        wait_drain("jump_wait");
    endtask

    task automatic test_misaligned();
        hold_reset();
        exp_req_q.push_back(32'hBFC0_0000);
        exp_req_q.push_back(32'hBFC0_0004);
        exp_req_q.push_back(32'h8000_0100);
        exp_ok(32'hBFC0_0000);
        exp_ok(32'hBFC0_0004);
        exp_adel(32'h8000_0002);
        exp_adel(32'h8000_0006);
        exp_ok(32'h8000_0100);
        mon_en = 1'b1;
        resetn = 1'b1;
        @(posedge clk); #1;
        jmp = 1'b1;
        jmp_target = 32'h8000_0002;
        @(posedge clk); #1;
        jmp = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h8000_0002 || inst !== 32'h0) begin
            failures++;
            $display("FAIL adel_slot: got req=%b pc=%h inst=%h expected 0 80000002 0", imem_req, pc, inst);
        end
        checks++;
        if (cp0_ex !== 1'b1 || cp0_excode !== 5'h04 || cp0_badvaddr !== 32'h8000_0002) begin
            failures++;
            $display("FAIL adel_cp0: got ex=%b code=%h bad=%h expected 1 04 80000002",
                     cp0_ex, cp0_excode, cp0_badvaddr);
        end
        @(posedge clk); #1;
        jmp = 1'b1;
        jmp_target = 32'h8000_0100;
        @(posedge clk); #1;
        jmp = 1'b0;
        wait_drain("misaligned");
    endtask

    task automatic test_flush();
        hold_reset();
        slow_addr = 32'hBFC0_0004;
        slow_wait = 3;
        exp_req_q.push_back(32'hBFC0_0000);
        exp_req_q.push_back(32'hBFC0_0004);
        exp_req_q.push_back(32'hBFC0_0380);
        exp_req_q.push_back(32'hBFC0_0384);
        exp_ok(32'hBFC0_0000);
        exp_ok(32'hBFC0_0380);
        exp_ok(32'hBFC0_0384);
        mon_en = 1'b1;
        resetn = 1'b1;
        @(posedge clk); #1;
        int_flush = 1'b1;
        int_target = 32'hBFC0_0380;
        jmp = 1'b1;
        jmp_target = 32'h8000_1000;
        @(posedge clk); #1;
        int_flush = 1'b0;
        jmp = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0004) begin
            failures++;
            $display("FAIL flush_drop_hold: got req=%b addr=%h expected 1 bfc00004", imem_req, imem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (imem_ack !== 1'b1 || pc !== 32'h0 || inst !== 32'h0) begin
            failures++;
            $display("FAIL flush_discard: got ack=%b pc=%h inst=%h expected 1 0 0", imem_ack, pc, inst);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0380) begin
            failures++;
            $display("FAIL flush_target_req: got req=%b addr=%h expected 1 bfc00380", imem_req, imem_addr);
        end
        wait_drain("flush");
    endtask

    task automatic test_reset_mid();
        hold_reset();
        slow_addr = 32'hBFC0_0004;
        slow_wait = 3;
        resetn = 1'b1;
        @(posedge clk); #4;
        resetn = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL midreset_req: got req=%b addr=%h expected 0 0", imem_req, imem_addr);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000 || inst !== 32'h2402_0001) begin
            failures++;
            $display("FAIL midreset_restart: got req=%b addr=%h inst=%h expected 1 bfc00000 24020001",
                     imem_req, imem_addr, inst);
        end
    endtask

    initial begin
        resetn = 1'b0;
        jmp = 1'b0; jmp_target = 32'h0; hazard_stall = 1'b0; exe_stall = 1'b0;
        int_flush = 1'b0; int_target = 32'h0;
        test_reset();
        test_stream();
        test_hold();
        test_jump_wait();
        test_misaligned();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_inst_fetch
`default_nettype wire
